// File: rtl/sdram_pkg.sv
// Shared constants and types for the SDRAM front-end arbiter.
// Master indices double as one-hot bit positions on the controller request tag.
package sdram_pkg;

  localparam int NUM_MASTERS  = 3;
  localparam int SDRAM_ADDR_W = 26;

  localparam logic [1:0] MASTER_ICACHE = 2'd0;
  localparam logic [1:0] MASTER_DCACHE = 2'd1;
  localparam logic [1:0] MASTER_VIDEO  = 2'd2;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE = 1'b0;
  localparam arb_state_t HOLD = 1'b1;

  // Round-robin successor, wrapping from the last master back to the first.
  function automatic logic [1:0] next_master(input logic [1:0] idx);
    return (idx == MASTER_VIDEO) ? MASTER_ICACHE : idx + 2'd1;
  endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Small FIFO of 2-bit master indices recording outstanding reads in acceptance order.
// Push and pop may occur together; a pop while empty is ignored.
module sdram_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [1:0] push_tag,
  input  logic       pop,
  output logic [1:0] pop_tag,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [1:0]     tags [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           do_push;
  logic           do_pop;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_tag = tags[rd_ptr[PTR_W-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) tags[wr_ptr[PTR_W-1:0]] <= push_tag;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter multiplexing three bus masters onto one SDRAM controller port,
// with in-order routing of untagged completion pulses back to the issuing master.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int RDQ_DEPTH = 4
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [NUM_MASTERS-1:0]                    m_request,
  output logic [NUM_MASTERS-1:0]                    m_ack,
  input  logic [NUM_MASTERS-1:0][SDRAM_ADDR_W-1:0]  m_address,
  input  logic [NUM_MASTERS-1:0]                    m_write,
  input  logic [NUM_MASTERS-1:0]                    m_burst,
  input  logic [NUM_MASTERS-1:0][3:0]               m_wstrb,
  input  logic [NUM_MASTERS-1:0][31:0]              m_wdata,
  output logic [NUM_MASTERS-1:0]                    m_rvalid,
  output logic [31:0]                               m_rdata,
  output logic [SDRAM_ADDR_W-1:0]                   m_raddress,
  output logic [NUM_MASTERS-1:0]                    m_complete,
  output logic [NUM_MASTERS-1:0]                    sdram_request,
  input  logic                                      sdram_ready,
  output logic [SDRAM_ADDR_W-1:0]                   sdram_address,
  output logic                                      sdram_write,
  output logic                                      sdram_burst,
  output logic [3:0]                                sdram_wstrb,
  output logic [31:0]                               sdram_wdata,
  input  logic [31:0]                               sdram_rdata,
  input  logic [SDRAM_ADDR_W-1:0]                   sdram_raddress,
  input  logic [NUM_MASTERS-1:0]                    sdram_rvalid,
  input  logic                                      sdram_complete,
  output logic                                      protocol_error
);

  arb_state_t             state;
  logic [1:0]             grant_idx;
  logic [1:0]             rr_ptr;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   found;
  logic [1:0]             winner;
  logic [1:0]             cand;
  logic                   grant_live;
  logic                   grant_dropped;
  logic                   accept;
  logic                   rdq_full;
  logic                   rdq_empty;
  logic                   rdq_pop;
  logic [1:0]             rdq_head;
  logic                   stray_complete;

  // Reads are held back while every RDQ slot is taken; writes may still pass.
  always_comb begin
    eligible = m_request & (m_write | {NUM_MASTERS{~rdq_full}});
    found    = 1'b0;
    winner   = rr_ptr;
    cand     = rr_ptr;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = next_master(cand);
    end
  end

  // Gating with the live request keeps a withdrawn grant from ever being accepted.
  assign grant_live     = (state == HOLD) && m_request[grant_idx];
  assign grant_dropped  = (state == HOLD) && !m_request[grant_idx];
  assign sdram_request  = grant_live ? (3'b001 << grant_idx) : 3'b000;
  assign accept         = sdram_ready && (sdram_request != 3'b000);
  assign m_ack          = accept ? sdram_request : 3'b000;

  assign sdram_address  = m_address[grant_idx];
  assign sdram_write    = m_write[grant_idx];
  assign sdram_burst    = m_burst[grant_idx];
  assign sdram_wstrb    = m_wstrb[grant_idx];
  assign sdram_wdata    = m_wdata[grant_idx];

  assign rdq_pop        = sdram_complete && !rdq_empty;
  assign stray_complete = sdram_complete && rdq_empty;
  assign m_complete     = rdq_pop ? (3'b001 << rdq_head) : 3'b000;

  assign m_rvalid       = sdram_rvalid;
  assign m_rdata        = sdram_rdata;
  assign m_raddress     = sdram_raddress;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      grant_idx      <= MASTER_ICACHE;
      rr_ptr         <= MASTER_ICACHE;
      protocol_error <= 1'b0;
    end else begin
      if (stray_complete || grant_dropped) protocol_error <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            grant_idx <= winner;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (grant_dropped) begin
            state <= IDLE;
          end else if (accept) begin
            rr_ptr <= next_master(grant_idx);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sdram_tag_fifo #(
    .DEPTH(RDQ_DEPTH)
  ) u_rdq (
    .clock    (clock),
    .reset    (reset),
    .push     (accept && !sdram_write),
    .push_tag (grant_idx),
    .pop      (rdq_pop),
    .pop_tag  (rdq_head),
    .full     (rdq_full),
    .empty    (rdq_empty)
  );

endmodule
